// File: rtl/secuenciador_alu.sv
// Purpose : issuing side of the ALU function/operand interface; registers requests, drives the ALU, captures corrected flags.
// Latency : request accepted in cycle T, ALU held stable in T+1 (EXEC), resValido high from cycle T+2 (DONE).
// Backpr. : opListo only in IDLE; the result is held in DONE until resValido&resListo, so one op per 3 cycles at best.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   opValida/opListo            request handshake; opCodigo, opA, opB, usarAcc request fields
//   funcionALU/vectorA/vectorB  registered drive into the ALU (change only on a legal acceptance)
//   resultado/zero/overflow     raw ALU outputs
//   resValido/resListo          result handshake; resDato, resZero, resOverflow, resError result fields
//   cuentaOps/cuentaErr         wrapping counters of legal completions / illegal opcodes
//
// Optional feature macro: SECUENCIADOR_ACUMULADOR_EN (accumulator feeding vectorA when usarAcc=1).
module secuenciador_alu #(
  parameter int BITS  = 8,
  parameter int FUNC  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             opValida,
  output logic             opListo,
  input  logic [FUNC-1:0]  opCodigo,
  input  logic [BITS-1:0]  opA,
  input  logic [BITS-1:0]  opB,
  input  logic             usarAcc,
  output logic [FUNC-1:0]  funcionALU,
  output logic [BITS-1:0]  vectorA,
  output logic [BITS-1:0]  vectorB,
  input  logic [BITS-1:0]  resultado,
  input  logic             zero,
  input  logic             overflow,
  output logic             resValido,
  input  logic             resListo,
  output logic [BITS-1:0]  resDato,
  output logic             resZero,
  output logic             resOverflow,
  output logic             resError,
  output logic [CNT_W-1:0] cuentaOps,
  output logic [CNT_W-1:0] cuentaErr
);

  localparam logic [FUNC-1:0] OP_ADD = FUNC'(0);
  localparam logic [FUNC-1:0] OP_SUB = FUNC'(1);
  localparam logic [FUNC-1:0] OP_XOR = FUNC'(2);
  localparam logic [FUNC-1:0] OP_AND = FUNC'(3);
  localparam logic [FUNC-1:0] OP_OR  = FUNC'(4);
  localparam logic [FUNC-1:0] OP_SHL = FUNC'(11);
  localparam logic [FUNC-1:0] OP_SHR = FUNC'(12);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} estado_t;

  estado_t         estado, estado_sig;
  logic            acepta;
  logic            captura;
  logic            legal_in;
  logic            pend_err;     // the in-flight request carried an illegal opcode
  logic            ovf_resta;
  logic            ovf_calc;
  logic [BITS-1:0] opA_sel;

  function automatic logic es_legal(input logic [FUNC-1:0] c);
    case (c)
      OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR, OP_SHL, OP_SHR: es_legal = 1'b1;
      default:                                               es_legal = 1'b0;
    endcase
  endfunction

  assign legal_in = es_legal(opCodigo);
  assign acepta   = opValida & opListo;
  assign captura  = (estado == EXEC);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= IDLE;
    else        estado <= estado_sig;
  end

  // Next state and handshake outputs
  always_comb begin
    estado_sig = estado;
    opListo    = 1'b0;
    resValido  = 1'b0;
    case (estado)
      IDLE: begin
        opListo = 1'b1;
        if (opValida) estado_sig = EXEC;
      end
      EXEC: estado_sig = DONE;
      DONE: begin
        resValido = 1'b1;
        if (resListo) estado_sig = IDLE;
      end
      default: estado_sig = IDLE;
    endcase
  end

  // Subtract overflow is derived locally from the operands actually driven
  // into the ALU; the ALU's own overflow output is not trusted for op 1.
  assign ovf_resta = (vectorA[BITS-1] != vectorB[BITS-1]) &
                     (resultado[BITS-1] != vectorA[BITS-1]);

  always_comb begin
    ovf_calc = 1'b0;
    case (funcionALU)
      OP_ADD:  ovf_calc = overflow;
      OP_SUB:  ovf_calc = ovf_resta;
      default: ovf_calc = 1'b0;
    endcase
  end

`ifdef SECUENCIADOR_ACUMULADOR_EN
  logic [BITS-1:0] acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  acc <= '0;
    else if (captura && !pend_err) acc <= resultado;
  end

  assign opA_sel = usarAcc ? acc : opA;
`else
  // usarAcc stays on the port list for interface compatibility only.
  logic unused_usaracc;
  assign unused_usaracc = usarAcc;
  assign opA_sel        = opA;
`endif

  // ALU drive, result capture and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funcionALU  <= '0;
      vectorA     <= '0;
      vectorB     <= '0;
      pend_err    <= 1'b0;
      resDato     <= '0;
      resZero     <= 1'b0;
      resOverflow <= 1'b0;
      resError    <= 1'b0;
      cuentaOps   <= '0;
      cuentaErr   <= '0;
    end else begin
      if (acepta) begin
        pend_err <= ~legal_in;
        // Illegal requests leave the ALU inputs untouched so the ALU is not reissued.
        if (legal_in) begin
          funcionALU <= opCodigo;
          vectorA    <= opA_sel;
          vectorB    <= opB;
        end
      end
      if (captura) begin
        if (pend_err) begin
          resDato     <= '0;
          resZero     <= 1'b0;
          resOverflow <= 1'b0;
          resError    <= 1'b1;
          cuentaErr   <= cuentaErr + CNT_W'(1);
        end else begin
          resDato     <= resultado;
          resZero     <= zero;
          resOverflow <= ovf_calc;
          resError    <= 1'b0;
          cuentaOps   <= cuentaOps + CNT_W'(1);
        end
      end
    end
  end

endmodule
